// File: rtl/rob.sv
// Reorder buffer: in-order allocation and retirement, out-of-order ALU/MUL/MEM writeback, precise exception flush.
// Optional operand bypass from ROB entries is enabled by defining ROB_BYPASS_EN.
module rob #(
  parameter int N = 8,
  parameter int WORD_SIZE = 32,
  parameter int ROB_ENTRY_WIDTH = 3,
  parameter int REG_INDEX_SIZE = 5,
  parameter logic [WORD_SIZE-1:0] INIT = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       require_rob_entry,
  input  logic                       is_store,
  input  logic [REG_INDEX_SIZE-1:0]  rd,
  input  logic                       d_exception,
  input  logic [WORD_SIZE-1:0]       d_pc,
  output logic [ROB_ENTRY_WIDTH-1:0] assigned_rob_id,
  output logic                       full,
  input  logic [WORD_SIZE-1:0]       alu_result,
  input  logic                       alu_rob_wenable,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
  input  logic [WORD_SIZE-1:0]       mul_result,
  input  logic                       mul_rob_wenable,
  input  logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id,
  input  logic [WORD_SIZE-1:0]       mem_result,
  input  logic                       mem_rob_wenable,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id,
  input  logic                       mem_exception,
  input  logic [WORD_SIZE-1:0]       mem_v_addr,
  input  logic [WORD_SIZE-1:0]       mem_pc,
  input  logic [ROB_ENTRY_WIDTH-1:0] rs1_rob_entry,
  input  logic [ROB_ENTRY_WIDTH-1:0] rs2_rob_entry,
  output logic [WORD_SIZE-1:0]       bypass_s1,
  output logic [WORD_SIZE-1:0]       bypass_s2,
  output logic                       bypass_s1_valid,
  output logic                       bypass_s2_valid,
  output logic                       commit,
  output logic [REG_INDEX_SIZE-1:0]  commit_rd,
  output logic [WORD_SIZE-1:0]       commit_value,
  output logic [ROB_ENTRY_WIDTH-1:0] commit_rob_entry,
  output logic                       sb_store_permission,
  output logic [ROB_ENTRY_WIDTH-1:0] sb_rob_id,
  output logic                       exception,
  output logic [WORD_SIZE-1:0]       ex_pc
);

  logic [ROB_ENTRY_WIDTH-1:0] head, tail;
  logic [ROB_ENTRY_WIDTH:0]   entries;
  logic [N-1:0]               valid, readys, exc, store_q;
  logic [REG_INDEX_SIZE-1:0]  rd_q [N];
  logic [WORD_SIZE-1:0]       value_q [N];
  logic [WORD_SIZE-1:0]       pc_q [N];
  logic [N-1:0][WORD_SIZE-1:0] addr_q;
  logic                       alloc, retire;

  function automatic logic [ROB_ENTRY_WIDTH-1:0] incr(input logic [ROB_ENTRY_WIDTH-1:0] p);
    return (p == ROB_ENTRY_WIDTH'(N - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full             = (entries == (ROB_ENTRY_WIDTH + 1)'(N));
  assign alloc            = require_rob_entry && !full;
  assign retire           = (entries != '0) && readys[head];
  assign commit           = retire && !exc[head];
  assign exception        = retire && exc[head];
  assign assigned_rob_id  = tail;
  assign commit_rd        = rd_q[head];
  assign commit_value     = value_q[head];
  assign commit_rob_entry = head;
  assign sb_store_permission = commit && store_q[head];
  assign sb_rob_id        = head;
  assign ex_pc            = pc_q[head];

  // Writebacks are ordered alu, mul, mem so the later assignment wins on a shared id.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      entries <= '0;
      valid   <= '0;
      readys  <= '0;
      exc     <= '0;
      store_q <= '0;
      addr_q  <= '0;
      for (int i = 0; i < N; i++) begin
        value_q[i] <= INIT;
        pc_q[i]    <= '0;
        rd_q[i]    <= '0;
      end
    end else if (exception) begin
      valid   <= '0;
      readys  <= '0;
      exc     <= '0;
      entries <= '0;
      tail    <= head;
    end else begin
      if (alu_rob_wenable && valid[alu_rob_id]) begin
        value_q[alu_rob_id] <= alu_result;
        readys[alu_rob_id]  <= 1'b1;
      end
      if (mul_rob_wenable && valid[mul_rob_id]) begin
        value_q[mul_rob_id] <= mul_result;
        readys[mul_rob_id]  <= 1'b1;
      end
      if (mem_rob_wenable && valid[mem_rob_id]) begin
        value_q[mem_rob_id] <= mem_result;
        readys[mem_rob_id]  <= 1'b1;
        exc[mem_rob_id]     <= mem_exception;
        pc_q[mem_rob_id]    <= mem_pc;
        addr_q[mem_rob_id]  <= mem_v_addr;
      end
      if (alloc) begin
        rd_q[tail]    <= rd;
        store_q[tail] <= is_store;
        pc_q[tail]    <= d_pc;
        exc[tail]     <= d_exception;
        readys[tail]  <= d_exception;
        valid[tail]   <= 1'b1;
        tail          <= incr(tail);
      end
      if (commit) begin
        valid[head]  <= 1'b0;
        readys[head] <= 1'b0;
        head         <= incr(head);
      end
      case ({alloc, commit})
        2'b10:   entries <= entries + 1'b1;
        2'b01:   entries <= entries - 1'b1;
        default: entries <= entries;
      endcase
    end
  end

`ifdef ROB_BYPASS_EN
  assign bypass_s1       = value_q[rs1_rob_entry];
  assign bypass_s2       = value_q[rs2_rob_entry];
  assign bypass_s1_valid = valid[rs1_rob_entry] && readys[rs1_rob_entry];
  assign bypass_s2_valid = valid[rs2_rob_entry] && readys[rs2_rob_entry];
  logic unused_addr;
  assign unused_addr = ^addr_q;
`else
  assign bypass_s1       = '0;
  assign bypass_s2       = '0;
  assign bypass_s1_valid = 1'b0;
  assign bypass_s2_valid = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{rs1_rob_entry, rs2_rob_entry, addr_q};
`endif

endmodule

// File: tb/tb_rob.sv
// Randomized self-checking bench for rob against an in-order queue model of the buffer.
// Directed sequences cover fill, drain, ALU commit, store release and exception flush.
module tb_rob;
  localparam int N = 8;

  typedef struct {
    int          id;
    logic [4:0]  rd;
    bit          is_store;
    logic [31:0] pc;
    bit          exc;
    bit          ready;
    logic [31:0] value;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        require_rob_entry, is_store, d_exception;
  logic [4:0]  rd;
  logic [31:0] d_pc;
  logic [2:0]  assigned_rob_id;
  logic        full;
  logic [31:0] alu_result, mul_result, mem_result, mem_v_addr, mem_pc;
  logic        alu_rob_wenable, mul_rob_wenable, mem_rob_wenable, mem_exception;
  logic [2:0]  alu_rob_id, mul_rob_id, mem_rob_id, rs1_rob_entry, rs2_rob_entry;
  logic [31:0] bypass_s1, bypass_s2;
  logic        bypass_s1_valid, bypass_s2_valid;
  logic        commit;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [2:0]  commit_rob_entry;
  logic        sb_store_permission;
  logic [2:0]  sb_rob_id;
  logic        exception;
  logic [31:0] ex_pc;

  ent_t q[$];
  int   head_id = 0;
  int   checks = 0;
  int   fails = 0;

  rob dut (
    .clk(clk), .rst(rst),
    .require_rob_entry(require_rob_entry), .is_store(is_store), .rd(rd),
    .d_exception(d_exception), .d_pc(d_pc),
    .assigned_rob_id(assigned_rob_id), .full(full),
    .alu_result(alu_result), .alu_rob_wenable(alu_rob_wenable), .alu_rob_id(alu_rob_id),
    .mul_result(mul_result), .mul_rob_wenable(mul_rob_wenable), .mul_rob_id(mul_rob_id),
    .mem_result(mem_result), .mem_rob_wenable(mem_rob_wenable), .mem_rob_id(mem_rob_id),
    .mem_exception(mem_exception), .mem_v_addr(mem_v_addr), .mem_pc(mem_pc),
    .rs1_rob_entry(rs1_rob_entry), .rs2_rob_entry(rs2_rob_entry),
    .bypass_s1(bypass_s1), .bypass_s2(bypass_s2),
    .bypass_s1_valid(bypass_s1_valid), .bypass_s2_valid(bypass_s2_valid),
    .commit(commit), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_rob_entry(commit_rob_entry),
    .sb_store_permission(sb_store_permission), .sb_rob_id(sb_rob_id),
    .exception(exception), .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    require_rob_entry = 0; is_store = 0; rd = 0; d_exception = 0; d_pc = 0;
    alu_result = 0; alu_rob_wenable = 0; alu_rob_id = 0;
    mul_result = 0; mul_rob_wenable = 0; mul_rob_id = 0;
    mem_result = 0; mem_rob_wenable = 0; mem_rob_id = 0;
    mem_exception = 0; mem_v_addr = 0; mem_pc = 0;
    rs1_rob_entry = 0; rs2_rob_entry = 0;
  endtask

  task automatic checkBypass(input string tag, input logic [2:0] rs, input logic [31:0] val, input logic vld);
    bit   found = 0;
    logic [31:0] v = 0;
    foreach (q[k]) if (q[k].id == int'(rs) && q[k].ready) begin found = 1; v = q[k].value; end
`ifdef ROB_BYPASS_EN
    checkOutput({tag, "_valid"}, vld, found);
    if (found) checkOutput(tag, val, v);
`else
    checkOutput({tag, "_valid"}, vld, 1'b0);
    checkOutput(tag, val, 32'h0);
`endif
  endtask

  // One cycle: compare outputs to the model at negedge, advance the model, then clock the DUT.
  task automatic applyStimulus();
    int   sz;
    bit   exp_commit, exp_exc, do_retire;
    int   alloc_id;
    ent_t e;
    @(negedge clk);
    sz = q.size();
    exp_commit = sz > 0 && q[0].ready && !q[0].exc;
    exp_exc    = sz > 0 && q[0].ready && q[0].exc;
    checkOutput("full", full, sz == N);
    checkOutput("assigned_rob_id", assigned_rob_id, (head_id + sz) % N);
    checkOutput("commit", commit, exp_commit);
    checkOutput("exception", exception, exp_exc);
    checkOutput("sb_store_permission", sb_store_permission, exp_commit && q[0].is_store);
    checkOutput("sb_rob_id", sb_rob_id, head_id);
    if (exp_commit) begin
      checkOutput("commit_rd", commit_rd, q[0].rd);
      checkOutput("commit_value", commit_value, q[0].value);
      checkOutput("commit_rob_entry", commit_rob_entry, head_id);
    end
    if (exp_exc) checkOutput("ex_pc", ex_pc, q[0].pc);
    checkBypass("bypass_s1", rs1_rob_entry, bypass_s1, bypass_s1_valid);
    checkBypass("bypass_s2", rs2_rob_entry, bypass_s2, bypass_s2_valid);

    if (rst) begin
      q.delete();
      head_id = 0;
    end else if (exp_exc) begin
      q.delete();
    end else begin
      do_retire = exp_commit;
      alloc_id  = (head_id + sz) % N;
      for (int k = 0; k < sz; k++) begin
        e = q[k];
        if (alu_rob_wenable && e.id == int'(alu_rob_id)) begin e.value = alu_result; e.ready = 1; end
        if (mul_rob_wenable && e.id == int'(mul_rob_id)) begin e.value = mul_result; e.ready = 1; end
        if (mem_rob_wenable && e.id == int'(mem_rob_id)) begin
          e.value = mem_result; e.ready = 1; e.exc = mem_exception; e.pc = mem_pc;
        end
        q[k] = e;
      end
      if (do_retire) begin
        void'(q.pop_front());
        head_id = (head_id + 1) % N;
      end
      if (require_rob_entry && sz < N) begin
        e = '{alloc_id, rd, is_store, d_pc, d_exception, d_exception, 32'h0};
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pickId();
    if (q.size() > 0 && $urandom_range(3, 0) != 0) return 3'(q[$urandom_range(q.size() - 1, 0)].id);
    return 3'($urandom_range(N - 1, 0));
  endfunction

  initial begin
    clearInputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Fill: ids 0..N-1 in order, then full.
    require_rob_entry = 1; rd = 1;
    for (int i = 0; i < N; i++) begin
      d_pc = 32'h1000 + 4 * i;
      applyStimulus();
    end
    applyStimulus();

    // Drain: make each entry ready, heads retire in order.
    clearInputs();
    for (int i = 0; i < N; i++) begin
      alu_rob_wenable = 1; alu_rob_id = 3'(i); alu_result = $urandom;
      applyStimulus();
    end
    clearInputs();
    repeat (2) applyStimulus();

    // ALU result committed.
    require_rob_entry = 1; rd = 5'd3;
    applyStimulus();
    clearInputs();
    alu_rob_wenable = 1; alu_rob_id = 3'(q[0].id); alu_result = 32'h55;
    applyStimulus();
    clearInputs();
    repeat (2) applyStimulus();

    // Store released to the store buffer.
    require_rob_entry = 1; is_store = 1; rd = 5'd7;
    applyStimulus();
    clearInputs();
    mem_rob_wenable = 1; mem_rob_id = 3'(q[0].id); mem_result = 32'hABCD;
    applyStimulus();
    clearInputs();
    repeat (2) applyStimulus();

    // Memory fault at head flushes the buffer, along with a younger entry.
    require_rob_entry = 1; rd = 5'd9;
    repeat (2) applyStimulus();
    clearInputs();
    mem_rob_wenable = 1; mem_rob_id = 3'(q[0].id); mem_exception = 1; mem_pc = 32'h100;
    applyStimulus();
    clearInputs();
    require_rob_entry = 1;
    applyStimulus();
    clearInputs();
    repeat (2) applyStimulus();

    // Randomized traffic with one reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      require_rob_entry = ($urandom_range(2, 0) != 0);
      is_store          = $urandom_range(1, 0);
      rd                = 5'($urandom);
      d_exception       = ($urandom_range(31, 0) == 0);
      d_pc              = $urandom;
      alu_rob_wenable   = $urandom_range(1, 0); alu_rob_id = pickId(); alu_result = $urandom;
      mul_rob_wenable   = $urandom_range(1, 0); mul_rob_id = pickId(); mul_result = $urandom;
      mem_rob_wenable   = $urandom_range(1, 0); mem_rob_id = pickId(); mem_result = $urandom;
      mem_exception     = ($urandom_range(15, 0) == 0);
      mem_v_addr        = $urandom;
      mem_pc            = $urandom;
      rs1_rob_entry     = 3'($urandom);
      rs2_rob_entry     = 3'($urandom);
      rst               = (c == 1500);
      applyStimulus();
    end
    rst = 0;
    clearInputs();
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameters (name, default, meaning): N 8 entry count; WORD_SIZE 32 data/address width; ROB_ENTRY_WIDTH 3 entry-index width, equal to log2(N); REG_INDEX_SIZE 5 architectural register index width; INIT 0 reset value of stored result words.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 require_rob_entry/is_store/rd/d_exception/d_pc  in  1/1/REG_INDEX_SIZE/1/WORD_SIZE  allocate request, store flag, destination register, decode exception flag, instruction PC.
REQ-005 assigned_rob_id/full  out  ROB_ENTRY_WIDTH/1  index allocated this cycle; no free entry.
REQ-006 alu_result/alu_rob_wenable/alu_rob_id  in  WORD_SIZE/1/ROB_ENTRY_WIDTH  ALU writeback.
REQ-007 mul_result/mul_rob_wenable/mul_rob_id  in  WORD_SIZE/1/ROB_ENTRY_WIDTH  multiplier writeback.
REQ-008 mem_result/mem_rob_wenable/mem_rob_id/mem_exception/mem_v_addr/mem_pc  in  WORD_SIZE/1/ROB_ENTRY_WIDTH/1/WORD_SIZE/WORD_SIZE  memory writeback with exception info.
REQ-009 rs1_rob_entry/rs2_rob_entry  in  ROB_ENTRY_WIDTH  operand tags; bypass_s1/bypass_s2  out  WORD_SIZE; bypass_s1_valid/bypass_s2_valid  out  1.
REQ-010 commit/commit_rd/commit_value/commit_rob_entry  out  1/REG_INDEX_SIZE/WORD_SIZE/ROB_ENTRY_WIDTH  head retirement.
REQ-011 sb_store_permission/sb_rob_id  out  1/ROB_ENTRY_WIDTH  store-buffer release of head store.
REQ-012 exception/ex_pc  out  1/WORD_SIZE  head entry faulted; its PC.

Function
REQ-013 Circular buffer with head, tail pointers (wrap N-1 -> 0) and occupancy counter named entries; per-entry ready flags in an array named readys; full = (entries == N).
REQ-014 Allocation when require_rob_entry && !full: assigned_rob_id = tail (combinational); next edge stores rd, is_store, d_pc, exception = d_exception, ready = d_exception, valid = 1; tail+1.
REQ-015 Writeback on wenable: value[id] <= result, ready[id] <= 1; mem also records exception = mem_exception, pc = mem_pc, addr = mem_v_addr; same-id priority mem > mul > alu; writes to invalid entries ignored.
REQ-016 Head retires when entries != 0 and readys[head] = 1: combinational commit = !exception[head], commit_rd/commit_value/commit_rob_entry from head; head+1 at next edge.
REQ-017 sb_store_permission = commit && is_store[head]; sb_rob_id = head.
REQ-018 exception = readys[head] && exception[head] && entries != 0; ex_pc = pc[head]; next edge flushes: all valid/readys cleared, entries = 0, tail = head; same-cycle allocation dropped.
REQ-019 Simultaneous allocate and retire: entries unchanged; retire only: -1; allocate only: +1.
REQ-020 Outputs are combinational from registered state; no output depends on same-cycle writeback.

Reset
REQ-021 On rst at clk edge: head = tail = entries = 0, all readys/valid/exception flags 0, values = INIT; hence full = 0, commit = 0, exception = 0, sb_store_permission = 0, bypass valids 0.

Configuration
REQ-022 ROB_BYPASS_EN defined: bypass_sX = value[rsX_rob_entry], bypass_sX_valid = valid && readys of that entry; undefined: bypass_sX = 0 and bypass_sX_valid = 0.

Verification
REQ-023 Reset, then require_rob_entry = 1, rd = 1, no writebacks for N cycles -> full = 1, assigned ids 0..N-1 in order.
REQ-024 From full, force all readys = 1, require_rob_entry = 0, wait N cycles -> commit each cycle ids 0..N-1, entries = 0, full = 0.
REQ-025 Allocate id 0, alu writeback id 0 value 0x55 -> next cycle commit = 1, commit_value = 0x55, commit_rd = rd.
REQ-026 Allocate store, mem writeback -> sb_store_permission = 1, sb_rob_id = 0, same cycle commit = 1.
REQ-027 mem writeback with mem_exception = 1, mem_pc = 0x100 at head -> exception = 1, ex_pc = 0x100, commit = 0, entries = 0 next cycle.
REQ-028 With ROB_BYPASS_EN, rs1_rob_entry = ready entry holding 0x7 -> bypass_s1 = 0x7, bypass_s1_valid = 1; non-ready entry -> valid = 0.
